fifo_rd_stream: RTL and testbench

//  Read-side drain engine for the dual-clock fifo in single-clock use (rd_clk = clk).

---
 rtl/fifo_pkg.sv | 5 +
 rtl/fifo_rd_skid.sv | 46 ++++
 rtl/fifo_rd_stream.sv | 59 +++++
 tb/tb_fifo_rd_stream.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared fifo width and occupancy type
package fifo_pkg;
    localparam int FIFO_DATA_WIDTH = 8;
    typedef logic [1:0] occ_t;
endpackage

// File: rtl/fifo_rd_skid.sv
// rtl/fifo_rd_skid.sv - 2-entry skid buffer with head/tail pointers and occupancy
module fifo_rd_skid
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output occ_t                  occ
);

    logic [DATA_WIDTH-1:0] mem [2];
    logic                  head;
    logic                  tail;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            head   <= 1'b0;
            tail   <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (wr_en) begin
                mem[tail] <= wr_data;
                tail      <= ~tail;
            end
            if (rd_en) begin
                head <= ~head;
            end
            // Write and read together leave occupancy unchanged
            case ({wr_en, rd_en})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    assign rd_data = mem[head];

endmodule

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - drains a fifo read port into a valid/ready byte stream
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]  xfer_count,
    output logic                  busy
);

    logic       inflight;
    occ_t       occ;
    logic       pop;
    logic [2:0] committed;

    assign out_valid = (occ != 2'd0);
    assign pop       = out_valid & out_ready;
    assign busy      = inflight | out_valid;

    // A read may issue only if buffered plus in-flight bytes, net of this cycle's pop, leave a free slot
    assign committed  = {1'b0, occ} + {2'b00, inflight};
    assign fifo_rd_en = enable & ~fifo_empty & ~rst
                      & (committed < (3'd2 + {2'b00, pop}));

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight   <= 1'b0;
            xfer_count <= '0;
        end else begin
            inflight <= fifo_rd_en;
            if (pop) begin
                xfer_count <= xfer_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    fifo_rd_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (inflight),
        .wr_data (fifo_rd_data),
        .rd_en   (pop),
        .rd_data (out_data),
        .occ     (occ)
    );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - randomized self-checking bench for fifo_rd_stream
module tb_fifo_rd_stream;

    localparam int DW  = 8;
    localparam int CW  = 4;
    localparam int MOD = 1 << CW;

    logic          clk;
    logic          rst;
    logic          enable;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] xfer_count;
    logic          busy;

    fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .xfer_count   (xfer_count),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference fifo contents and the byte stream seen at the consumer
    logic [DW-1:0] q[$];
    logic [DW-1:0] got[$];
    int            rd_pulses;
    bit            rd_while_empty;
    bit            stall_violation;
    bit            prev_stall;
    logic [DW-1:0] prev_data;

    // One clock: sample pre-edge at negedge, then update the fifo model 1 unit after posedge
    task automatic tick();
        logic          rd;
        logic          pp;
        logic [DW-1:0] d;
        @(negedge clk);
        rd = fifo_rd_en;
        pp = out_valid & out_ready;
        d  = out_data;
        if (rd && fifo_empty) rd_while_empty = 1'b1;
        if (rd) rd_pulses++;
        if (prev_stall && !rst && (!out_valid || out_data !== prev_data)) stall_violation = 1'b1;
        prev_stall = out_valid & ~out_ready & ~rst;
        prev_data  = out_data;
        @(posedge clk);
        #1;
        if (!rst && pp) got.push_back(d);
        if (rd && q.size() > 0) fifo_rd_data = q.pop_front();
        else                    fifo_rd_data = DW'($urandom);
        fifo_empty = (q.size() == 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        q.delete();
        got.delete();
        fifo_empty = 1'b1;
        rd_pulses = 0;
        prev_stall = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b1;
        out_ready = 1'b1;
        q = {8'h55};
        fifo_empty = 1'b0;
        tick();
        tick();
        n_checks++; if (fifo_rd_en !== 1'b0) $display("FAIL reset_rd_en got=%b exp=0", fifo_rd_en); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else n_pass++;
        n_checks++; if (xfer_count !== '0) $display("FAIL reset_xfer_count got=%0d exp=0", xfer_count); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
        n_checks++; if (out_data !== '0) $display("FAIL reset_out_data got=%h exp=00", out_data); else n_pass++;
        q.delete();
        fifo_empty = 1'b1;
    endtask

    task automatic test_basic();
        logic [DW-1:0] exp_seq [3] = '{8'h11, 8'h22, 8'h33};
        got.delete();
        q = {8'h11, 8'h22, 8'h33};
        fifo_empty = 1'b0;
        out_ready = 1'b1;
        rst = 1'b0;
        #1;
        n_checks++; if (fifo_rd_en !== 1'b1) $display("FAIL basic_first_rd_en got=%b exp=1", fifo_rd_en); else n_pass++;
        tick();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL basic_valid_n1 got=%b exp=0", out_valid); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== exp_seq[i])
                $display("FAIL basic_byte%0d got=%b/%h exp=1/%h", i, out_valid, out_data, exp_seq[i]);
            else n_pass++;
        end
        tick();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL basic_drained_valid got=%b exp=0", out_valid); else n_pass++;
        n_checks++; if (xfer_count !== CW'(3)) $display("FAIL basic_xfer_count got=%0d exp=3", xfer_count); else n_pass++;
        n_checks++; if (fifo_rd_en !== 1'b0) $display("FAIL basic_rd_en_after got=%b exp=0", fifo_rd_en); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL basic_busy_after got=%b exp=0", busy); else n_pass++;
    endtask

    task automatic test_stall();
        int cyc;
        do_reset();
        out_ready = 1'b0;
        stall_violation = 1'b0;
        q = {8'hA0, 8'hA1, 8'hA2, 8'hA3};
        fifo_empty = 1'b0;
        #1;
        for (int i = 0; i < 6; i++) tick();
        n_checks++; if (rd_pulses !== 2) $display("FAIL stall_rd_pulses got=%0d exp=2", rd_pulses); else n_pass++;
        n_checks++; if (out_valid !== 1'b1 || out_data !== 8'hA0)
            $display("FAIL stall_head got=%b/%h exp=1/a0", out_valid, out_data); else n_pass++;
        n_checks++; if (q.size() !== 2) $display("FAIL stall_fifo_left got=%0d exp=2", q.size()); else n_pass++;
        out_ready = 1'b1;
        cyc = 0;
        while (got.size() < 4 && cyc < 20) begin tick(); cyc++; end
        n_checks++;
        if (got.size() != 4 || got[0] !== 8'hA0 || got[1] !== 8'hA1 || got[2] !== 8'hA2 || got[3] !== 8'hA3)
            $display("FAIL stall_release got_n=%0d exp=4 bytes a0..a3", got.size());
        else n_pass++;
        n_checks++; if (stall_violation !== 1'b0) $display("FAIL stall_stable got=%b exp=0", stall_violation); else n_pass++;
    endtask

    task automatic test_random();
        logic [DW-1:0] pending[$];
        int cyc;
        int bad;
        do_reset();
        stall_violation = 1'b0;
        rd_while_empty = 1'b0;
        for (int i = 0; i < 200; i++) pending.push_back(DW'(i));
        cyc = 0;
        while (got.size() < 200 && cyc < 5000) begin
            if (pending.size() > 0 && $urandom_range(0, 9) < 6) begin
                q.push_back(pending.pop_front());
                fifo_empty = 1'b0;
            end
            out_ready = 1'($urandom_range(0, 1));
            #1;
            tick();
            cyc++;
        end
        bad = 0;
        for (int i = 0; i < got.size(); i++) if (got[i] !== DW'(i)) bad++;
        n_checks++; if (got.size() != 200 || bad != 0)
            $display("FAIL random_order got_n=%0d bad=%0d exp=200/0", got.size(), bad); else n_pass++;
        out_ready = 1'b0;
        #1;
        n_checks++; if (xfer_count !== CW'(200 % MOD))
            $display("FAIL random_xfer_count got=%0d exp=%0d", xfer_count, 200 % MOD); else n_pass++;
        n_checks++; if (rd_while_empty !== 1'b0) $display("FAIL random_rd_while_empty got=1 exp=0"); else n_pass++;
        n_checks++; if (stall_violation !== 1'b0) $display("FAIL random_stable got=1 exp=0"); else n_pass++;
    endtask

    task automatic test_enable_drop();
        do_reset();
        enable = 1'b1;
        out_ready = 1'b1;
        q = {8'h51, 8'h52, 8'h53, 8'h54, 8'h55};
        fifo_empty = 1'b0;
        #1;
        tick();
        tick();
        enable = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) tick();
        n_checks++; if (got.size() != 2 || got[0] !== 8'h51 || got[1] !== 8'h52)
            $display("FAIL enable_drain got_n=%0d exp=2 (51,52)", got.size()); else n_pass++;
        n_checks++; if (rd_pulses !== 2) $display("FAIL enable_rd_pulses got=%0d exp=2", rd_pulses); else n_pass++;
        n_checks++; if (q.size() !== 3) $display("FAIL enable_fifo_left got=%0d exp=3", q.size()); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL enable_busy got=%b exp=0", busy); else n_pass++;
        enable = 1'b1;
    endtask

    task automatic test_wrap_and_reset();
        int cyc;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) q.push_back(DW'(8'h80 + i));
        fifo_empty = 1'b0;
        #1;
        cyc = 0;
        while (got.size() < 17 && cyc < 100) begin tick(); cyc++; end
        tick();
        n_checks++; if (got.size() != 17 || xfer_count !== CW'(17 % MOD))
            $display("FAIL wrap_xfer_count got=%0d/%0d exp=%0d/17", xfer_count, got.size(), 17 % MOD); else n_pass++;

        out_ready = 1'b0;
        q = {8'hC1, 8'hC2, 8'hC3};
        fifo_empty = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) tick();
        n_checks++; if (out_valid !== 1'b1 || q.size() !== 1)
            $display("FAIL midrst_full got=%b/%0d exp=1/1", out_valid, q.size()); else n_pass++;
        rst = 1'b1;
        tick();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL midrst_valid got=%b exp=0", out_valid); else n_pass++;
        n_checks++; if (xfer_count !== '0) $display("FAIL midrst_xfer_count got=%0d exp=0", xfer_count); else n_pass++;
        rst = 1'b0;
        got.delete();
        out_ready = 1'b1;
        #1;
        cyc = 0;
        while (got.size() < 1 && cyc < 10) begin tick(); cyc++; end
        n_checks++; if (got.size() < 1 || got[0] !== 8'hC3)
            $display("FAIL midrst_next_byte got_n=%0d exp=c3", got.size()); else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b1;
        out_ready = 1'b0;
        fifo_empty = 1'b1;
        fifo_rd_data = '0;
        rd_pulses = 0;
        rd_while_empty = 1'b0;
        stall_violation = 1'b0;
        prev_stall = 1'b0;
        prev_data = '0;
        test_reset();
        test_basic();
        test_stall();
        test_random();
        test_enable_drop();
        test_wrap_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
